sd_cmd_serial_tx: RTL and testbench

//  Serialises one 48-bit SD command frame onto the CMD line: start bit, transmission bit,
//  6-bit index, 32-bit argument, CRC-7 and end bit.

---
 rtl/sd_cmd_serial_tx.sv | 125 ++++++++++++
 tb/tb_sd_cmd_serial_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_serial_tx.sv
// sd_cmd_serial_tx: serialises a 48-bit SD command frame with inline CRC-7 and Ncc gap
module sd_cmd_serial_tx #(
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        cmd_out_o,
  output logic        cmd_oe_o,
  output logic        bit_strb_o,
  output logic [6:0]  crc_out_o
);
  typedef enum logic [2:0] {IDLE, SEND, CRC, STOP, GAP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d, bit_q, bit_d;
  logic [39:0] shift_q, shift_d;
  logic [6:0]  crc_q, crc_d, crc_upd;
  logic        out_q, out_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d, strb_q, strb_d;
  logic        wrap, inv;
  assign wrap    = div_q == 8'(BIT_DIV - 1);
  assign inv     = out_q ^ crc_q[6];
  assign crc_upd = {crc_q[5:3], crc_q[2] ^ inv, crc_q[1:0], inv};
  // shift_q[39] is always the next bit to drive; the CRC and end bit are reloaded into it after bit 39
  always_comb begin
    state_d = state_q;
    div_d   = wrap ? 8'd0 : div_q + 8'd1;
    bit_d   = wrap ? bit_q + 8'd1 : bit_q;
    shift_d = shift_q;
    crc_d   = crc_q;
    out_d   = out_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    strb_d  = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = 8'd0;
        bit_d = 8'd0;
        if (start_i) begin
          state_d = SEND;
          shift_d = {1'b1, cmd_idx_i, cmd_arg_i, 1'b0};
          crc_d   = 7'd0;
          out_d   = 1'b0;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          strb_d  = 1'b1;
        end
      end
      SEND: if (wrap) begin
        strb_d  = 1'b1;
        crc_d   = crc_upd;
        out_d   = bit_q == 8'd39 ? crc_upd[6] : shift_q[39];
        shift_d = bit_q == 8'd39 ? {crc_upd[5:0], 1'b1, 33'd0} : {shift_q[38:0], 1'b0};
        state_d = bit_q == 8'd39 ? CRC : SEND;
      end
      CRC: if (wrap) begin
        strb_d  = 1'b1;
        out_d   = shift_q[39];
        shift_d = {shift_q[38:0], 1'b0};
        state_d = bit_q == 8'd46 ? STOP : CRC;
      end
      STOP: if (wrap) begin
        bit_d   = 8'd0;
        oe_d    = 1'b0;
        out_d   = 1'b1;
        state_d = GAP_BITS == 0 ? IDLE : GAP;
        busy_d  = GAP_BITS != 0;
        done_d  = GAP_BITS == 0;
      end
      GAP: if (wrap && bit_q == 8'(GAP_BITS - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      div_d   = 8'd0;
      bit_d   = 8'd0;
      out_d   = 1'b1;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      strb_d  = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 8'd0;
      shift_q <= 40'd0;
      crc_q   <= 7'd0;
      out_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      strb_q  <= strb_d;
    end
  end
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cmd_out_o  = out_q;
  assign cmd_oe_o   = oe_q;
  assign bit_strb_o = strb_q;
  assign crc_out_o  = crc_q;
endmodule

// File: tb/tb_sd_cmd_serial_tx.sv
// tb_sd_cmd_serial_tx: randomized and directed checks of the SD CMD serializer against a division-based CRC model
module tb_sd_cmd_serial_tx;
  logic clk = 1'b0;
  logic rst, start, abort, busy, done, out, oe, strb;
  logic [5:0] idx;
  logic [31:0] arg;
  logic [6:0] crc;
  logic f_start, f_abort, f_busy, f_done, f_out, f_oe, f_strb;
  logic [5:0] f_idx;
  logic [31:0] f_arg;
  logic [6:0] f_crc;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sd_cmd_serial_tx #(.BIT_DIV(4), .GAP_BITS(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .cmd_idx_i(idx), .cmd_arg_i(arg),
    .busy_o(busy), .done_o(done), .cmd_out_o(out), .cmd_oe_o(oe), .bit_strb_o(strb), .crc_out_o(crc));
  sd_cmd_serial_tx #(.BIT_DIV(2), .GAP_BITS(0)) u_fast (
    .clk_i(clk), .rst_i(rst), .start_i(f_start), .abort_i(f_abort), .cmd_idx_i(f_idx), .cmd_arg_i(f_arg),
    .busy_o(f_busy), .done_o(f_done), .cmd_out_o(f_out), .cmd_oe_o(f_oe), .bit_strb_o(f_strb), .crc_out_o(f_crc));
  // CRC-7 as the remainder of message*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction
  function automatic logic [47:0] frame_of(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] m;
    m = {2'b01, i, a};
    return {m, crc7(m), 1'b1};
  endfunction
  task automatic drive_start(input logic [5:0] i, input logic [31:0] a, input logic ab);
    @(negedge clk);
    start = 1'b1; idx = i; arg = a; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask
  task automatic collect(input bit noisy, output logic [47:0] fr, output int oe_n, output int strb_n,
                         output int gap_n, output int done_n, output logic [6:0] crc40);
    bit fin;
    fin = 0; fr = '0; oe_n = 0; strb_n = 0; gap_n = 0; done_n = 0; crc40 = '0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (oe) oe_n++; else if (busy) gap_n++;
      if (strb) begin fr = {fr[46:0], out}; strb_n++; if (strb_n == 41) crc40 = crc; end
      if (done) begin done_n++; fin = 1; end
      if (noisy) begin start = oe; idx = 6'($urandom); arg = $urandom; end
      if (!fin) @(negedge clk);
    end
    if (noisy) start = 1'b0;
  endtask
  task automatic advance_to_strb(input int n);
    int k;
    k = 0;
    for (int c = 0; c < 400 && k < n; c++) begin
      if (strb) k++;
      if (k < n) @(negedge clk);
    end
    checks++;
    if (k !== n) begin errors++; $display("FAIL advance_strb got %0d want %0d", k, n); end
  endtask
  task automatic check_frame(input string nm, input logic [47:0] exp_fr, input logic [6:0] exp_crc,
                             input bit full);
    logic [47:0] fr; logic [6:0] c40; int oe_n, strb_n, gap_n, done_n;
    collect(0, fr, oe_n, strb_n, gap_n, done_n, c40);
    checks++; if (fr !== exp_fr) begin errors++; $display("FAIL %s_frame got %h want %h", nm, fr, exp_fr); end
    checks++; if (c40 !== exp_crc) begin errors++; $display("FAIL %s_crc got %h want %h", nm, c40, exp_crc); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL %s_done got %0d want 1", nm, done_n); end
    if (full) begin
      checks++; if (oe_n !== 192) begin errors++; $display("FAIL %s_oe got %0d want 192", nm, oe_n); end
      checks++; if (strb_n !== 48) begin errors++; $display("FAIL %s_strb got %0d want 48", nm, strb_n); end
      checks++; if (gap_n !== 32) begin errors++; $display("FAIL %s_gap got %0d want 32", nm, gap_n); end
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; idx = 0; arg = 0; f_start = 0; f_abort = 0; f_idx = 0; f_arg = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, out, oe, strb, crc} !== 12'b0_0_1_0_0_0000000) begin
      errors++; $display("FAIL reset got %b want 001000000000", {busy, done, out, oe, strb, crc});
    end
    checks++;
    if ({f_busy, f_done, f_out, f_oe, f_strb, f_crc} !== 12'b0_0_1_0_0_0000000) begin
      errors++; $display("FAIL reset_fast got %b want 001000000000", {f_busy, f_done, f_out, f_oe, f_strb, f_crc});
    end
    rst = 1'b0;
  endtask
  task automatic test_cmd0;
    drive_start(6'd0, 32'd0, 1'b0);
    check_frame("cmd0", 48'h40_00000000_95, 7'h4A, 1);
  endtask
  task automatic test_cmd8_cmd17;
    drive_start(6'd8, 32'h000001AA, 1'b0);
    check_frame("cmd8", 48'h48_000001AA_87, 7'h43, 1);
    drive_start(6'd17, 32'd0, 1'b1);
    check_frame("cmd17_abort_idle", 48'h51_00000000_55, 7'h2A, 1);
  endtask
  task automatic test_back_to_back;
    logic [47:0] fr; logic [6:0] c40; int oe_n, strb_n, gap_n, done_n;
    logic [5:0] i2; logic [31:0] a2;
    drive_start(6'd55, 32'd0, 1'b0);
    collect(0, fr, oe_n, strb_n, gap_n, done_n, c40);
    checks++; if (fr !== 48'h77_00000000_65) begin errors++; $display("FAIL b2b_first got %h want 77000000006 5", fr); end
    checks++; if (c40 !== 7'h32) begin errors++; $display("FAIL b2b_crc got %h want 32", c40); end
    i2 = 6'($urandom); a2 = $urandom;
    start = 1'b1; idx = i2; arg = a2;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({oe, strb, out} !== 3'b110) begin errors++; $display("FAIL b2b_restart got %b want 110", {oe, strb, out}); end
    check_frame("b2b_second", frame_of(i2, a2), crc7({2'b01, i2, a2}), 1);
  endtask
  task automatic test_start_held;
    logic [47:0] fr; logic [6:0] c40; int oe_n, strb_n, gap_n, done_n, extra;
    logic [5:0] i; logic [31:0] a;
    i = 6'($urandom); a = $urandom;
    drive_start(i, a, 1'b0);
    collect(1, fr, oe_n, strb_n, gap_n, done_n, c40);
    checks++; if (fr !== frame_of(i, a)) begin errors++; $display("FAIL held_frame got %h want %h", fr, frame_of(i, a)); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL held_done got %0d want 1", done_n); end
    extra = 0;
    repeat (8) begin @(negedge clk); if (done || busy) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL held_extra got %0d want 0", extra); end
  endtask
  task automatic test_abort_and_rst;
    int bad; logic [5:0] i; logic [31:0] a;
    drive_start(6'($urandom), $urandom, 1'b0);
    advance_to_strb(21);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({oe, out, busy, done, strb} !== 5'b01000) begin errors++; $display("FAIL abort_out got %b want 01000", {oe, out, busy, done, strb}); end
    bad = 0;
    repeat (60) begin @(negedge clk); if (done || busy || oe) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet got %0d want 0", bad); end
    i = 6'($urandom); a = $urandom;
    drive_start(i, a, 1'b0);
    check_frame("after_abort", frame_of(i, a), crc7({2'b01, i, a}), 1);
    drive_start(6'($urandom), $urandom, 1'b0);
    advance_to_strb(45);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({oe, out, busy, done, strb, crc} !== 12'b0_1_0_0_0_0000000) begin
      errors++; $display("FAIL rst_mid got %b want 010000000000", {oe, out, busy, done, strb, crc});
    end
    bad = 0;
    repeat (40) begin @(negedge clk); if (done || busy) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_quiet got %0d want 0", bad); end
    i = 6'($urandom); a = $urandom;
    drive_start(i, a, 1'b0);
    check_frame("after_rst", frame_of(i, a), crc7({2'b01, i, a}), 1);
  endtask
  task automatic test_random;
    logic [5:0] i; logic [31:0] a;
    for (int n = 0; n < 4; n++) begin
      i = 6'($urandom); a = $urandom;
      drive_start(i, a, 1'b0);
      check_frame("random", frame_of(i, a), crc7({2'b01, i, a}), n == 0);
    end
  endtask
  task automatic test_fast;
    logic [47:0] fr; int oe_n, strb_n; bit fin, done_at_fall;
    logic [5:0] i; logic [31:0] a;
    i = 6'($urandom); a = $urandom;
    @(negedge clk);
    f_start = 1'b1; f_idx = i; f_arg = a;
    @(negedge clk);
    f_start = 1'b0;
    fr = '0; oe_n = 0; strb_n = 0; fin = 0; done_at_fall = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (f_oe) begin
        oe_n++;
        if (f_strb) begin fr = {fr[46:0], f_out}; strb_n++; end
        @(negedge clk);
      end else begin
        done_at_fall = f_done && !f_busy;
        fin = 1;
      end
    end
    checks++; if (oe_n !== 96) begin errors++; $display("FAIL fast_oe got %0d want 96", oe_n); end
    checks++; if (done_at_fall !== 1'b1) begin errors++; $display("FAIL fast_done got %0d want 1", done_at_fall); end
    checks++; if (fr !== frame_of(i, a)) begin errors++; $display("FAIL fast_frame got %h want %h", fr, frame_of(i, a)); end
    checks++; if (strb_n !== 48) begin errors++; $display("FAIL fast_strb got %0d want 48", strb_n); end
    @(negedge clk);
    checks++; if (f_done !== 1'b0) begin errors++; $display("FAIL fast_done_width got %0d want 0", f_done); end
  endtask
  initial begin
    test_reset;
    test_cmd0;
    test_cmd8_cmd17;
    test_back_to_back;
    test_start_held;
    test_abort_and_rst;
    test_random;
    test_fast;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
